// File: rtl/rvv_seq_ctrl.sv
// Vector instruction sequencer: accepts one RVV command, computes vl, and walks the LMUL register group.
// Optional tail masking of the last written register is enabled by defining RVV_SEQ_TAIL_MASK_EN.
module rvv_seq_ctrl #(
    parameter int VLEN    = 64,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [4:0]        cmd_vs1,
    input  logic [4:0]        cmd_vs2,
    input  logic [4:0]        cmd_vd,
    input  logic [31:0]       cmd_scalar,
    input  logic [2:0]        sew_encoded_id,
    input  logic [2:0]        lmul_encoded_id,
    input  logic [7:0]        AVL,
    output logic [3:0]        valu_op,
    output logic [2:0]        sew_encoded_q,
    output logic [31:0]       alu_scalar_in_id,
    output logic [4:0]        raA,
    output logic [4:0]        raB,
    output logic [4:0]        wa,
    output logic              wen,
    output logic [VLEN/8-1:0] wmask,
    output logic [7:0]        vl,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WM        = VLEN / 8;
    localparam int VLEN_LOG2 = $clog2(VLEN);
    localparam int WB_LOG2   = $clog2(WM);
    localparam int LAT_W     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int CNT_W     = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [2:0]         lmul_q;
    logic [4:0]         vs1_q;
    logic [4:0]         vs2_q;
    logic [4:0]         vd_q;
    logic [7:0]         avl_q;
    logic               err_q;
    logic [CNT_W-1:0]   nregs_q;
    logic [CNT_W-1:0]   idx;
    logic [LAT_W-1:0]   lat_cnt;

    logic [2:0]         sew_log2;
    logic [5:0]         lmul_n;
    logic [31:0]        vlmax;
    logic [7:0]         vl_calc;
    logic [15:0]        bits_calc;
    logic [CNT_W-1:0]   nregs_calc;
    logic               sew_ok;
    logic               lmul_ok;
    logic               illegal;
    logic               last;

    // A group base must be LMUL-aligned and the whole group must fit in v0..v31.
    function automatic logic base_ok(input logic [4:0] base, input logic [5:0] n);
        return ((base & (n[4:0] - 5'd1)) == 5'd0) && (({1'b0, base} + n - 6'd1) <= 6'd31);
    endfunction

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        sew_log2   = sew_encoded_q + 3'd2;
        lmul_n     = 6'd1 << lmul_q[1:0];
        vlmax      = (32'(VLEN) << lmul_q[1:0]) >> sew_log2;
        vl_calc    = ({24'd0, avl_q} < vlmax) ? avl_q : vlmax[7:0];
        bits_calc  = 16'(vl_calc) << sew_log2;
        nregs_calc = (CNT_W'(bits_calc) + CNT_W'(VLEN - 1)) >> VLEN_LOG2;
        sew_ok     = (sew_encoded_q >= 3'b001) && (sew_encoded_q <= 3'b100);
        lmul_ok    = !lmul_q[2];
        illegal    = !sew_ok || !lmul_ok
                   || !base_ok(vs1_q, lmul_n)
                   || (!valu_op[0] && !base_ok(vs2_q, lmul_n))
                   || !base_ok(vd_q, lmul_n);
    end

    assign last = (idx == nregs_q - 1'b1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cmd_valid) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (illegal || vl_calc == 8'd0) ? S_DONE : S_READ;
            S_READ:   if (lat_cnt == LAT_W'(ALU_LAT - 1)) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last ? S_DONE : S_READ;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            valu_op          <= '0;
            sew_encoded_q    <= '0;
            alu_scalar_in_id <= '0;
            lmul_q           <= '0;
            vs1_q            <= '0;
            vs2_q            <= '0;
            vd_q             <= '0;
            avl_q            <= '0;
            raA              <= '0;
            raB              <= '0;
            wa               <= '0;
            vl               <= '0;
            err_q            <= 1'b0;
            nregs_q          <= '0;
            idx              <= '0;
            lat_cnt          <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        valu_op          <= cmd_op;
                        sew_encoded_q    <= sew_encoded_id;
                        alu_scalar_in_id <= cmd_scalar;
                        lmul_q           <= lmul_encoded_id;
                        vs1_q            <= cmd_vs1;
                        vs2_q            <= cmd_vs2;
                        vd_q             <= cmd_vd;
                        avl_q            <= AVL;
                    end
                end
                S_DECODE: begin
                    err_q   <= illegal;
                    nregs_q <= nregs_calc;
                    idx     <= '0;
                    lat_cnt <= '0;
                    if (!illegal) vl <= vl_calc;
                    // Addresses only move when a group is actually walked; otherwise they keep their last value.
                    if (!illegal && vl_calc != 8'd0) begin
                        raA <= vs1_q;
                        raB <= vs2_q;
                        wa  <= vd_q;
                    end
                end
                S_READ: lat_cnt <= lat_cnt + 1'b1;
                S_WRITE: begin
                    if (!last) begin
                        idx     <= idx + 1'b1;
                        raA     <= raA + 5'd1;
                        raB     <= raB + 5'd1;
                        wa      <= wa + 5'd1;
                        lat_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status strobes decode straight from the state register, so reset clears them asynchronously.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wen       = (state == S_WRITE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_DONE) && err_q;

`ifdef RVV_SEQ_TAIL_MASK_EN
    logic [2:0]         byte_shift;
    logic [WB_LOG2-1:0] body_rem;

    always_comb begin
        byte_shift = sew_encoded_q - 3'd1;
        body_rem   = WB_LOG2'(16'(vl) << byte_shift);
        wmask      = '1;
        if (state == S_WRITE && last && body_rem != '0)
            wmask = (WM'(1) << body_rem) - WM'(1);
    end
`else
    assign wmask = '1;
`endif

endmodule

// File: tb/tb_rvv_seq_ctrl.sv
// Self-checking bench for rvv_seq_ctrl: expected register writes are queued per command
// and compared as wen pulses appear; latency, err and vl are checked at done.
module tb_rvv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_vs1, cmd_vs2, cmd_vd;
    logic [31:0] cmd_scalar;
    logic [2:0]  sew_encoded_id, lmul_encoded_id;
    logic [7:0]  AVL;
    logic [3:0]  valu_op;
    logic [2:0]  sew_encoded_q;
    logic [31:0] alu_scalar_in_id;
    logic [4:0]  raA, raB, wa;
    logic        wen;
    logic [7:0]  wmask;
    logic [7:0]  vl;
    logic        busy, done, err;

    rvv_seq_ctrl #(.VLEN(64), .ALU_LAT(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_vs1          (cmd_vs1),
        .cmd_vs2          (cmd_vs2),
        .cmd_vd           (cmd_vd),
        .cmd_scalar       (cmd_scalar),
        .sew_encoded_id   (sew_encoded_id),
        .lmul_encoded_id  (lmul_encoded_id),
        .AVL              (AVL),
        .valu_op          (valu_op),
        .sew_encoded_q    (sew_encoded_q),
        .alu_scalar_in_id (alu_scalar_in_id),
        .raA              (raA),
        .raB              (raB),
        .wa               (wa),
        .wen              (wen),
        .wmask            (wmask),
        .vl               (vl),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] wa;
        logic [7:0] mask;
    } wr_t;

    wr_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Scoreboard: every wen pulse must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (wen === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_wen got wa=%0d raA=%0d, expected no write", wa, raA);
            end else begin
                e = sb.pop_front();
                if (raA !== e.ra || raB !== e.rb || wa !== e.wa || wmask !== e.mask) begin
                    n_fail++;
                    $display("FAIL write got raA=%0d raB=%0d wa=%0d wmask=%h, expected raA=%0d raB=%0d wa=%0d wmask=%h",
                             raA, raB, wa, wmask, e.ra, e.rb, e.wa, e.mask);
                end
            end
        end
    end

    function automatic logic [7:0] tail_mask(input int nbytes);
        int   rem;
        logic en;
`ifdef RVV_SEQ_TAIL_MASK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        rem = nbytes % 8;
        tail_mask = 8'hFF;
        if (en && rem != 0) tail_mask = 8'((1 << rem) - 1);
    endfunction

    task automatic push_group(input int v1, input int v2, input int vd, input int n, input int total_bytes);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.ra   = 5'(v1 + i);
            e.rb   = 5'(v2 + i);
            e.wa   = 5'(vd + i);
            e.mask = (i == n - 1) ? tail_mask(total_bytes) : 8'hFF;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] sew, input logic [2:0] lmul,
                        input logic [7:0] avl, input logic [4:0] v1, input logic [4:0] v2,
                        input logic [4:0] vd, input logic [31:0] sc, output int t_acc);
        int k;
        @(negedge clk);
        cmd_op = op; sew_encoded_id = sew; lmul_encoded_id = lmul; AVL = avl;
        cmd_vs1 = v1; cmd_vs2 = v2; cmd_vd = vd; cmd_scalar = sc;
        cmd_valid = 1'b1;
        for (k = 0; k < 100 && cmd_ready !== 1'b1; k++) @(negedge clk);
        if (k == 100) begin
            $display("FAIL accept_timeout cmd_ready never rose");
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1;
        t_acc     = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int t_acc, input int exp_lat, input logic exp_err);
        int k;
        int lat;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        n_tests++;
        if (k == 200) begin
            n_fail++;
            $display("FAIL %s_done_timeout got no done, expected done after %0d cycles", name, exp_lat);
            return;
        end
        lat = cyc + 1 - t_acc;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency got %0d expected %0d", name, lat, exp_lat);
        end
        n_tests++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err got %b expected %b", name, err, exp_err);
        end
        n_tests++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_status_at_done got ready=%b busy=%b expected ready=0 busy=1", name, cmd_ready, busy);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes got %0d pending expected 0", name, sb.size());
        end
    endtask

    task automatic check8(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vd = '0;
        cmd_scalar = '0; sew_encoded_id = '0; lmul_encoded_id = '0; AVL = '0;
        #12;
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || wen !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status got ready=%b busy=%b wen=%b done=%b err=%b expected 1 0 0 0 0",
                     cmd_ready, busy, wen, done, err);
        end
        n_tests++;
        if (wmask !== 8'hFF || vl !== 8'd0 || raA !== 5'd0 || raB !== 5'd0 || wa !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_values got wmask=%h vl=%0d raA=%0d raB=%0d wa=%0d expected ff 0 0 0 0",
                     wmask, vl, raA, raB, wa);
        end
        n_tests++;
        if (valu_op !== 4'd0 || sew_encoded_q !== 3'd0 || alu_scalar_in_id !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_held got op=%0d sew=%0d scalar=%h expected 0 0 0",
                     valu_op, sew_encoded_q, alu_scalar_in_id);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int t;
        push_group(2, 3, 4, 1, 8);
        send(4'b0000, 3'b001, 3'b000, 8'd16, 5'd2, 5'd3, 5'd4, 32'd0, t);
        wait_done("t1", t, 4, 1'b0);
        check8("t1_vl", 32'(vl), 32'd8);
        check8("t1_sew_q", 32'(sew_encoded_q), 32'd1);
    endtask

    task automatic test_illegal();
        int t;
        send(4'b0000, 3'b001, 3'b010, 8'd16, 5'd0, 5'd4, 5'd6, 32'd0, t);
        wait_done("t4_misaligned", t, 2, 1'b1);
        check8("t4_vl_kept", 32'(vl), 32'd8);
        check8("t4_raA_kept", 32'(raA), 32'd2);
        send(4'b0000, 3'b101, 3'b000, 8'd16, 5'd0, 5'd1, 5'd2, 32'd0, t);
        wait_done("bad_sew", t, 2, 1'b1);
        send(4'b0000, 3'b001, 3'b100, 8'd16, 5'd0, 5'd1, 5'd2, 32'd0, t);
        wait_done("bad_lmul", t, 2, 1'b1);
        check8("bad_vl_kept", 32'(vl), 32'd8);
    endtask

    task automatic test_zero_avl();
        int t;
        send(4'b0000, 3'b011, 3'b001, 8'd0, 5'd2, 5'd4, 5'd6, 32'd0, t);
        wait_done("t3", t, 2, 1'b0);
        check8("t3_vl", 32'(vl), 32'd0);
    endtask

    task automatic test_group();
        int t;
        push_group(4, 12, 8, 3, 20);
        send(4'b0011, 3'b010, 3'b010, 8'd10, 5'd4, 5'd12, 5'd8, 32'hDEADBEEF, t);
        wait_done("t2", t, 8, 1'b0);
        check8("t2_vl", 32'(vl), 32'd10);
        check8("t2_op", 32'(valu_op), 32'd3);
        check8("t2_scalar", alu_scalar_in_id, 32'hDEADBEEF);
    endtask

    task automatic test_lmul8();
        int t;
        push_group(0, 8, 24, 8, 64);
        send(4'b0010, 3'b001, 3'b011, 8'd255, 5'd0, 5'd8, 5'd24, 32'd0, t);
        wait_done("lmul8", t, 18, 1'b0);
        check8("lmul8_vl", 32'(vl), 32'd64);
    endtask

    task automatic test_tail();
        int t;
        push_group(1, 2, 3, 1, 5);
        send(4'b0001, 3'b001, 3'b000, 8'd5, 5'd1, 5'd2, 5'd3, 32'h55, t);
        wait_done("t6", t, 4, 1'b0);
        check8("t6_vl", 32'(vl), 32'd5);
    endtask

    task automatic test_ignore_busy();
        int t;
        push_group(2, 3, 4, 1, 8);
        send(4'b0000, 3'b001, 3'b000, 8'd16, 5'd2, 5'd3, 5'd4, 32'd0, t);
        cmd_valid = 1'b1; cmd_vs1 = 5'd9; cmd_vd = 5'd17; sew_encoded_id = 3'b111; cmd_op = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("ignore_busy", t, 4, 1'b0);
        check8("ignore_busy_op", 32'(valu_op), 32'd0);
    endtask

    task automatic test_back_to_back();
        int t;
        push_group(2, 3, 4, 1, 8);
        send(4'b0000, 3'b001, 3'b000, 8'd16, 5'd2, 5'd3, 5'd4, 32'd0, t);
        wait_done("b2b_a", t, 4, 1'b0);
        push_group(8, 10, 12, 2, 16);
        send(4'b0000, 3'b001, 3'b001, 8'd16, 5'd8, 5'd10, 5'd12, 32'd0, t);
        wait_done("b2b_b", t, 6, 1'b0);
        check8("b2b_vl", 32'(vl), 32'd16);
    endtask

    task automatic test_reset_mid();
        int t;
        int k;
        push_group(4, 12, 8, 3, 20);
        send(4'b0000, 3'b010, 3'b010, 8'd10, 5'd4, 5'd12, 5'd8, 32'd0, t);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wen === 1'b1) break;
        end
        n_tests++;
        if (k == 50) begin
            n_fail++;
            $display("FAIL t5_first_wen got none expected a write");
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        n_tests++;
        if (wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_async got wen=%b busy=%b done=%b expected 0 0 0", wen, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check8("t5_ready", 32'(cmd_ready), 32'd1);
        check8("t5_vl_reset", 32'(vl), 32'd0);
        repeat (10) @(negedge clk);
        check8("t5_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_illegal();
        test_zero_avl();
        test_group();
        test_lmul8();
        test_tail();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
